xif_mem_bridge: RTL
===================

XIF_MEM_BRIDGE -- requirements
Module: xif_mem_bridge

Interface
REQ-001 SHALL have parameter X_ID_WIDTH, default 4, width of the transaction ID.
REQ-002 SHALL have parameter XLEN, default 32, address and data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for bus_rvalid, range 1..255.
REQ-004 SHALL have ports: ck  in  1  clock, rising-edge active.
REQ-005 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: mem_valid  in  1  coprocessor memory request valid.
REQ-007 SHALL have ports: mem_ready  out  1  bridge accepts request.
REQ-008 SHALL have ports: mem_id  in  X_ID_WIDTH  request ID.
REQ-009 SHALL have ports: mem_addr  in  XLEN  byte address.
REQ-010 SHALL have ports: mem_wdata  in  XLEN  store data.
REQ-011 SHALL have ports: mem_we  in  1  1=store, 0=load.
REQ-012 SHALL have ports: mem_size  in  3  log2 access bytes (0..2 legal).
REQ-013 SHALL have ports: mem_be  in  XLEN/8  byte enables.
REQ-014 SHALL have ports: mem_resp_exc  out  1  request raised exception.
REQ-015 SHALL have ports: mem_result_valid  out  1  one-cycle result strobe.
REQ-016 SHALL have ports: mem_result_id  out  X_ID_WIDTH  ID of completed request.
REQ-017 SHALL have ports: mem_result_rdata  out  XLEN  load data, 0 for stores.
REQ-018 SHALL have ports: mem_result_err  out  1  bus error or timeout.
REQ-019 SHALL have ports: bus_req  out  1; bus_gnt  in  1; bus_addr  out  XLEN; bus_we  out  1; bus_be  out  XLEN/8; bus_wdata  out  XLEN; bus_rvalid  in  1; bus_rdata  in  XLEN; bus_err  in  1 -- OBI-style data bus.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, WAIT, RESP.
REQ-021 SHALL drive mem_ready=1 only in IDLE; mem_valid&&mem_ready captures id/addr/wdata/we/be into registers and moves to REQ next cycle.
REQ-022 SHALL drive mem_resp_exc combinationally in the handshake cycle (0 unless REQ-035 applies).
REQ-023 SHALL assert bus_req in REQ with captured fields stable until bus_gnt; bus_req&&bus_gnt moves to WAIT.
REQ-024 SHALL, in WAIT, on bus_rvalid capture bus_rdata (loads) or 0 (stores) and bus_err, then move to RESP.
REQ-025 SHALL count WAIT cycles; when count reaches TIMEOUT without bus_rvalid, set err=1, rdata=0, move to RESP; later bus_rvalid for that access is ignored.
REQ-026 SHALL assert mem_result_valid for exactly one cycle in RESP with registered id/rdata/err, then return to IDLE.
REQ-027 SHALL hold mem_result_* at last values when mem_result_valid=0.
REQ-028 SHALL allow at most one outstanding transaction; minimum latency handshake->result strobe is 3 cycles (gnt and rvalid each in first eligible cycle).
REQ-029 SHALL ignore bus_rvalid outside WAIT and bus_gnt outside REQ.
REQ-030 SHALL treat bus_rvalid and timeout in the same cycle as bus_rvalid winning (err=bus_err).

Reset
REQ-031 SHALL, on rst low, enter IDLE immediately, abandoning any in-flight access.
REQ-032 SHALL reset mem_ready=0 during reset, bus_req=0, mem_result_valid=0, mem_result_id=0, mem_result_rdata=0, mem_result_err=0, mem_resp_exc=0, timeout counter=0.
REQ-033 SHALL drive mem_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-034 SHALL use macro XIF_MEM_ALIGN_CHECK_EN.
REQ-035 SHALL, when defined, flag misaligned access (addr not multiple of 2^mem_size) or mem_size>2 with mem_resp_exc=1 in the handshake cycle, not issue bus_req, and go directly to RESP with err=1, rdata=0.
REQ-036 SHALL, when undefined, never assert mem_resp_exc and forward all requests to the bus.

Verification
REQ-037 SHALL cover: load id=3 addr=0x100, gnt immediate, rvalid next cycle rdata=0xDEADBEEF -> result strobe id=3 rdata=0xDEADBEEF err=0, 3 cycles after handshake.
REQ-038 SHALL cover: store id=5 wdata=0x12345678 be=0xF, gnt delayed 4 cycles -> bus_req held with stable addr/wdata, result id=5 rdata=0 err=0.
REQ-039 SHALL cover: TIMEOUT=8, load never answered -> result err=1 rdata=0 after 8 WAIT cycles; stray rvalid afterwards ignored.
REQ-040 SHALL cover: bus_err=1 with rvalid -> mem_result_err=1; next request accepted in following cycle.
REQ-041 SHALL cover: rst low while in WAIT -> all outputs 0 asynchronously, no result strobe, mem_ready=1 after release.
REQ-042 SHALL cover: with XIF_MEM_ALIGN_CHECK_EN, load addr=0x102 size=2 -> mem_resp_exc=1, no bus_req, result err=1; without macro -> bus access issued.

Source files
------------

// File: rtl/xif_mem_bridge.sv
// Bridges single-outstanding coprocessor memory requests onto an OBI-style data bus.
// Defining XIF_MEM_ALIGN_CHECK_EN rejects misaligned/oversized requests locally.
module xif_mem_bridge #(
    parameter int X_ID_WIDTH = 4,
    parameter int XLEN       = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [X_ID_WIDTH-1:0] mem_id,
    input  logic [XLEN-1:0]       mem_addr,
    input  logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_we,
    input  logic [2:0]            mem_size,
    input  logic [XLEN/8-1:0]     mem_be,
    output logic                  mem_resp_exc,
    output logic                  mem_result_valid,
    output logic [X_ID_WIDTH-1:0] mem_result_id,
    output logic [XLEN-1:0]       mem_result_rdata,
    output logic                  mem_result_err,
    output logic                  bus_req,
    input  logic                  bus_gnt,
    output logic [XLEN-1:0]       bus_addr,
    output logic                  bus_we,
    output logic [XLEN/8-1:0]     bus_be,
    output logic [XLEN-1:0]       bus_wdata,
    input  logic                  bus_rvalid,
    input  logic [XLEN-1:0]       bus_rdata,
    input  logic                  bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic   [7:0]            r_count;
    logic   [X_ID_WIDTH-1:0] r_id;
    logic   [XLEN-1:0]       r_addr;
    logic   [XLEN-1:0]       r_wdata;
    logic                    r_we;
    logic   [XLEN/8-1:0]     r_be;
    logic   [X_ID_WIDTH-1:0] r_res_id;
    logic   [XLEN-1:0]       r_res_rdata;
    logic                    r_res_err;
    logic                    w_idle;
    logic                    w_accept;
    logic                    w_misaligned;
    logic                    w_timeout;

    // Ready is gated by reset so the handshake cannot be seen while reset is held.
    assign w_idle    = (r_state == IDLE) && rst;
    assign w_accept  = mem_valid && w_idle;
    assign w_timeout = (r_state == WAIT) && !bus_rvalid && (r_count == LP_LAST);

`ifdef XIF_MEM_ALIGN_CHECK_EN
    always_comb begin
        w_misaligned = 1'b0;
        case (mem_size)
            3'd0:    w_misaligned = 1'b0;
            3'd1:    w_misaligned = mem_addr[0];
            3'd2:    w_misaligned = |mem_addr[1:0];
            default: w_misaligned = 1'b1;
        endcase
    end
`else
    logic w_unused_size;
    assign w_unused_size = ^mem_size;
    assign w_misaligned  = 1'b0;
`endif

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_misaligned ? RESP : REQ;
            REQ:     if (bus_gnt) w_next = WAIT;
            WAIT:    if (bus_rvalid || w_timeout) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_ready        = w_idle;
        bus_req          = (r_state == REQ);
        mem_result_valid = (r_state == RESP);
        mem_resp_exc     = w_accept && w_misaligned;
    end

    // Counts consecutive WAIT cycles; restarts whenever WAIT is left or not yet entered.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst)                                      r_count <= '0;
        else if ((r_state == WAIT) && (w_next == WAIT)) r_count <= r_count + 8'd1;
        else                                           r_count <= '0;
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_id    <= mem_id;
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_we    <= mem_we;
            r_be    <= mem_be;
        end
    end

    // Result registers only change on entry to RESP, so they hold between strobes.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_res_id    <= '0;
            r_res_rdata <= '0;
            r_res_err   <= 1'b0;
        end else if (w_accept && w_misaligned) begin
            r_res_id    <= mem_id;
            r_res_rdata <= '0;
            r_res_err   <= 1'b1;
        end else if ((r_state == WAIT) && bus_rvalid) begin
            r_res_id    <= r_id;
            r_res_rdata <= r_we ? '0 : bus_rdata;
            r_res_err   <= bus_err;
        end else if (w_timeout) begin
            r_res_id    <= r_id;
            r_res_rdata <= '0;
            r_res_err   <= 1'b1;
        end
    end

    assign bus_addr         = r_addr;
    assign bus_we           = r_we;
    assign bus_be           = r_be;
    assign bus_wdata        = r_wdata;
    assign mem_result_id    = r_res_id;
    assign mem_result_rdata = r_res_rdata;
    assign mem_result_err   = r_res_err;

endmodule
